// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: valid/ready handshake bundle around one elastic pipeline stage.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 80,
    parameter int CTRL_W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: registered valid/ready stage with a skid entry, flush to bubble and a saturating stall counter.
module pipe_stage_elastic #(
    parameter int                 DATA_W      = 80,
    parameter int                 CTRL_W      = 9,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pipe_stage_elastic_if.slave    bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_fire;
    logic              out_fire;

    assign in_fire       = bus.in_valid & ~skid_valid;
    assign out_fire      = out_valid & bus.out_ready;
    // in_ready comes straight off the skid flop, so out_ready never reaches it combinationally
    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_ctrl  = out_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= CTRL_BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= CTRL_BUBBLE;
            stall_cnt  <= '0;
        end else begin
            if (out_valid && !bus.out_ready && stall_cnt != {STALL_CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (flush) begin
                out_valid  <= 1'b0;
                out_ctrl   <= CTRL_BUBBLE;
                skid_valid <= 1'b0;
                skid_ctrl  <= CTRL_BUBBLE;
            end else if (skid_valid) begin
                if (out_fire) begin
                    out_data   <= skid_data;
                    out_ctrl   <= skid_ctrl;
                    skid_valid <= 1'b0;
                end
            end else if (out_valid) begin
                if (in_fire && out_fire) begin
                    out_data <= bus.in_data;
                    out_ctrl <= bus.in_ctrl;
                end else if (in_fire) begin
                    skid_data  <= bus.in_data;
                    skid_ctrl  <= bus.in_ctrl;
                    skid_valid <= 1'b1;
                end else if (out_fire) begin
                    out_valid <= 1'b0;
                    out_ctrl  <= CTRL_BUBBLE;
                end
            end else if (in_fire) begin
                out_data  <= bus.in_data;
                out_ctrl  <= bus.in_ctrl;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed vector table, stall/saturation sequence and random back-pressure scoreboard.
module tb_pipe_stage_elastic;
    logic        clk = 0;
    logic        rst;
    logic        flush;
    logic [15:0] st16;
    logic [3:0]  st4;
    int          checks = 0;
    int          failures = 0;

    pipe_stage_elastic_if #(.DATA_W(80), .CTRL_W(9)) b ();
    pipe_stage_elastic_if #(.DATA_W(80), .CTRL_W(9)) b4 ();

    assign b4.in_valid  = b.in_valid;
    assign b4.in_data   = b.in_data;
    assign b4.in_ctrl   = b.in_ctrl;
    assign b4.out_ready = b.out_ready;

    pipe_stage_elastic u0 (.clk(clk), .rst(rst), .flush(flush), .bus(b.slave), .stall_cnt(st16));
    pipe_stage_elastic #(.STALL_CNT_W(4)) u1 (.clk(clk), .rst(rst), .flush(flush), .bus(b4.slave), .stall_cnt(st4));

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        er;
        logic [7:0]  ed;
        logic [15:0] es;
    } vec_t;

    vec_t          tv[21];
    logic [88:0]   q[$];
    logic [88:0]   exp_beat;
    logic [79:0]   seq;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [79:0] d, input logic ordy, input logic fl);
        b.in_valid  = iv;
        b.in_data   = d;
        b.in_ctrl   = 9'h100 | 9'(d[7:0]);
        b.out_ready = ordy;
        flush       = fl;
    endtask

    task automatic do_reset();
        rst = 1;
        drive(1, 80'h0, 0, 0);
        b.in_ctrl = 9'h1FF;
        cyc();
        cyc();
        rst = 0;
    endtask

    initial begin
        tv = '{
            '{1, 8'h01, 1, 0, 1, 1, 8'h01, 16'd0},
            '{1, 8'h02, 1, 0, 1, 1, 8'h02, 16'd0},
            '{1, 8'h03, 1, 0, 1, 1, 8'h03, 16'd0},
            '{1, 8'h04, 1, 0, 1, 1, 8'h04, 16'd0},
            '{1, 8'h05, 1, 0, 1, 1, 8'h05, 16'd0},
            '{1, 8'h06, 1, 0, 1, 1, 8'h06, 16'd0},
            '{1, 8'h07, 1, 0, 1, 1, 8'h07, 16'd0},
            '{1, 8'h08, 1, 0, 1, 1, 8'h08, 16'd0},
            '{0, 8'h00, 1, 0, 0, 1, 8'h08, 16'd0},
            '{1, 8'h0A, 0, 0, 1, 1, 8'h0A, 16'd0},
            '{1, 8'h0B, 0, 0, 1, 0, 8'h0A, 16'd1},
            '{1, 8'h0C, 0, 0, 1, 0, 8'h0A, 16'd2},
            '{1, 8'h0C, 1, 0, 1, 1, 8'h0B, 16'd2},
            '{1, 8'h0C, 1, 0, 1, 1, 8'h0C, 16'd2},
            '{0, 8'h00, 1, 0, 0, 1, 8'h0C, 16'd2},
            '{1, 8'h11, 0, 0, 1, 1, 8'h11, 16'd2},
            '{1, 8'h22, 0, 0, 1, 0, 8'h11, 16'd3},
            '{1, 8'hDD, 0, 1, 0, 1, 8'h11, 16'd4},
            '{0, 8'h00, 1, 0, 0, 1, 8'h11, 16'd4},
            '{1, 8'h33, 1, 1, 0, 1, 8'h11, 16'd4},
            '{0, 8'h00, 1, 0, 0, 1, 8'h11, 16'd4}
        };
        do_reset();
        chk("rst_out_valid", 128'(b.out_valid), 128'(0));
        chk("rst_out_ctrl", 128'(b.out_ctrl), 128'(0));
        chk("rst_in_ready", 128'(b.in_ready), 128'(1));
        chk("rst_stall", 128'(st16), 128'(0));
        chk("rst_out_data", 128'(b.out_data), 128'(0));

        for (int i = 0; i < 21; i++) begin
            drive(tv[i].iv, 80'(tv[i].d), tv[i].ordy, tv[i].fl);
            cyc();
            chk($sformatf("v%0d_out_valid", i), 128'(b.out_valid), 128'(tv[i].ev));
            chk($sformatf("v%0d_in_ready", i), 128'(b.in_ready), 128'(tv[i].er));
            chk($sformatf("v%0d_out_data", i), 128'(b.out_data), 128'(tv[i].ed));
            chk($sformatf("v%0d_out_ctrl", i), 128'(b.out_ctrl), tv[i].ev ? 128'(9'h100 | 9'(tv[i].ed)) : 128'(0));
            chk($sformatf("v%0d_stall", i), 128'(st16), 128'(tv[i].es));
        end

        // 20 stall cycles: 16-bit counter reads 20, 4-bit counter pins at 15
        do_reset();
        drive(1, 80'h44, 0, 0);
        cyc();
        drive(0, 80'h0, 0, 0);
        repeat (20) cyc();
        chk("stall_w16", 128'(st16), 128'(20));
        chk("stall_w4_sat", 128'(st4), 128'(15));
        chk("stall_hold_valid", 128'(b.out_valid), 128'(1));
        chk("stall_hold_data", 128'(b.out_data), 128'(8'h44));
        drive(0, 80'h0, 1, 0);
        cyc();
        chk("stall_drain_valid", 128'(b.out_valid), 128'(0));
        chk("stall_after_drain", 128'(st16), 128'(20));

        do_reset();
        seq = 80'h1;
        for (int i = 0; i < 1000; i++) begin
            b.in_valid  = 1'($urandom_range(0, 1));
            b.out_ready = 1'($urandom_range(0, 1));
            b.in_data   = seq;
            b.in_ctrl   = seq[8:0];
            flush       = 0;
            if (!b.out_valid)
                chk("rand_bubble_ctrl", 128'(b.out_ctrl), 128'(0));
            if (b.out_valid && b.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_beat", 128'(1), 128'(0));
                end else begin
                    exp_beat = q.pop_front();
                    chk("rand_order", 128'({b.out_ctrl, b.out_data}), 128'(exp_beat));
                end
            end
            if (b.in_valid && b.in_ready) begin
                q.push_back({seq[8:0], seq});
                seq++;
            end
            cyc();
        end
        b.in_valid  = 0;
        b.out_ready = 1;
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            if (b.out_valid) begin
                exp_beat = q.pop_front();
                chk("drain_order", 128'({b.out_ctrl, b.out_data}), 128'(exp_beat));
            end
            cyc();
        end
        chk("drain_empty", 128'(q.size()), 128'(0));
        chk("drain_out_valid", 128'(b.out_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline stage register for the pipelined datapath. It is the successor to the fixed-width stage registers between S1/S2/S3. It carries a DATA_W-bit datapath payload and a CTRL_W-bit control payload under a valid/ready handshake, with a two-entry skid buffer so that back-pressure never drops a beat. A flush input squashes the stage to a bubble, and a saturating counter reports downstream stall cycles.

## Interface
Parameters:
- DATA_W, 80: datapath payload width (e.g. ReadData1, ReadData2, Immediate).
- CTRL_W, 9: control payload width (e.g. DataSource, ALUop, WriteSelect, WriteEnable).
- CTRL_BUBBLE, {CTRL_W{1'b0}}: control value presented when the stage is empty, flushed or reset.
- STALL_CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: squash the stage contents (synchronous).
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: stage can accept a beat; registered.
- in_data, input, DATA_W: upstream datapath payload.
- in_ctrl, input, CTRL_W: upstream control payload.
- out_valid, output, 1: beat present at output; registered.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, DATA_W: registered datapath payload.
- out_ctrl, output, CTRL_W: registered control payload; equals CTRL_BUBBLE whenever out_valid=0.
- stall_cnt, output, STALL_CNT_W: count of cycles with out_valid=1 and out_ready=0; saturating.

## Operation
- Storage: main entry (drives outputs) and skid entry (skid_valid, skid_data, skid_ctrl).
- Beat terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- The stage has three states:
  - EMPTY: out_valid=0, skid_valid=0.
  - FULL: out_valid=1, skid_valid=0.
  - SKID: out_valid=1, skid_valid=1.
- in_ready = !skid_valid; it is a registered signal.
- Transitions when flush=0:
  - EMPTY, in_fire: main <= in, go to FULL. Without in_fire, stay EMPTY.
  - FULL, in_fire & out_fire: main <= in, stay FULL.
  - FULL, in_fire & !out_fire: skid <= in, go to SKID.
  - FULL, !in_fire & out_fire: go to EMPTY; out_ctrl <= CTRL_BUBBLE and out_data holds its value.
  - FULL, no fire: hold.
  - SKID: in_fire is impossible because in_ready=0; in_valid is ignored. On out_fire: main <= skid, skid_valid <= 0, go to FULL. Otherwise hold.
- Flush has highest priority after rst:
  - Next state is EMPTY and skid_valid <= 0.
  - out_ctrl and skid_ctrl <= CTRL_BUBBLE; out_data holds.
  - A beat accepted (in_fire) in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered.
- Ordering: beats leave in exactly the order accepted. No beat is dropped or duplicated except by flush.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready, including during flush cycles.
  - Saturates at 2^STALL_CNT_W-1 with no wrap.
  - Cleared only by rst.

## Timing
- Reset values: out_valid=0, in_ready=1, skid_valid=0, out_data=0, skid_data=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0.
- rst dominates flush and all handshakes. rst asserted mid-transfer discards both entries.
- Latency: a beat accepted at edge N appears on out_* from cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure: out_ready falling while FULL accepts one more beat into skid. in_ready drops the following cycle.
- Recovery: in_ready returns to 1 the cycle after the out_fire that drains skid. Draining skid takes 1 cycle.
- Combinational paths: none from out_ready to in_ready, and none from inputs to outputs.

## Test plan
- Reset/idle: assert rst 2 cycles with in_valid=1 and in_ctrl=0x1FF. Required: out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, push data 1..8 on consecutive cycles. Required: out_data 1..8 on cycles N+1..N+8, no gaps, in_ready stays 1.
- Skid capture: push A, B, C back-to-back while out_ready=0 from B's acceptance cycle. Required: A held at output, B captured in skid, in_ready=0 and C not accepted. Raise out_ready: output order A, B, C, with in_ready=1 one cycle after A leaves.
- Flush in SKID state: fill A and B, then assert flush with in_valid=1 carrying D. Required: next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1; D, A and B are never delivered.
- Stall counter: hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt=20. With STALL_CNT_W=4 and 20 stall cycles, stall_cnt=15.
- Randomised back-pressure: random in_valid/out_ready for 1000 cycles. Scoreboard requires in-order delivery, no loss or duplication, and out_ctrl=CTRL_BUBBLE whenever out_valid=0.
